// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks one- or two-word instructions out of a synchronous instruction memory.
// Optional macro FETCH_WRAP_TRAP_EN turns a PC wrap past the top of memory into a sticky fetch_err stop.
module instr_fetch #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_word,
  output logic [DATA_W-1:0] instr_imm,
  output logic              instr_has_imm,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_err
);

  typedef enum logic [2:0] {
    S_ADDR,
    S_OP,
    S_ADDR_IMM,
    S_IMM,
    S_VALID
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic              cap_op;
  logic              cap_imm;
  logic              load_instr_pc;
  logic              pc_inc;
  logic              wrap_trap;
  logic              two_word;

  // Addressing mode 2'b10 marks an instruction followed by an immediate word.
  assign two_word    = (mem_data[DATA_W-1 -: 2] == 2'b10);
  assign mem_addr    = pc;
  assign instr_valid = (state == S_VALID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_ADDR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    cap_op        = 1'b0;
    cap_imm       = 1'b0;
    load_instr_pc = 1'b0;
    pc_inc        = 1'b0;
    wrap_trap     = 1'b0;
    case (state)
      S_ADDR: begin
        if (fetch_en && !fetch_err) begin
          state_next    = S_OP;
          load_instr_pc = 1'b1;
        end
      end
      S_OP: begin
        cap_op     = 1'b1;
        state_next = two_word ? S_ADDR_IMM : S_VALID;
      end
      S_ADDR_IMM: state_next = S_IMM;
      S_IMM: begin
        cap_imm    = 1'b1;
        state_next = S_VALID;
      end
      S_VALID: begin
        if (instr_ready) state_next = S_ADDR;
      end
      default: state_next = S_ADDR;
    endcase
    pc_inc = cap_op | cap_imm;
`ifdef FETCH_WRAP_TRAP_EN
    wrap_trap = pc_inc && (&pc);
`else
    wrap_trap = 1'b0;
`endif
    // A trapped wrap abandons the instruction being assembled.
    if (wrap_trap) begin
      state_next = S_ADDR;
      cap_op     = 1'b0;
      cap_imm    = 1'b0;
    end
    // A redirect overrides everything: the partial instruction is discarded untouched.
    if (redirect_valid) begin
      state_next    = S_ADDR;
      cap_op        = 1'b0;
      cap_imm       = 1'b0;
      load_instr_pc = 1'b0;
      pc_inc        = 1'b0;
      wrap_trap     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_PC;
      instr_word    <= '0;
      instr_imm     <= '0;
      instr_has_imm <= 1'b0;
      instr_pc      <= '0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_addr;
      end else if (pc_inc) begin
        pc <= pc + ADDR_W'(1);
      end
      if (load_instr_pc) instr_pc <= pc;
      if (cap_op) begin
        instr_word    <= mem_data;
        instr_has_imm <= two_word;
        if (!two_word) instr_imm <= '0;
      end
      if (cap_imm) instr_imm <= mem_data;
    end
  end

`ifdef FETCH_WRAP_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_err <= 1'b0;
    end else if (wrap_trap) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: synchronous instruction memory model plus hand-computed expectations.
// Covers both the default build and FETCH_WRAP_TRAP_EN.
module tb_instr_fetch;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              fetch_en = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [DATA_W-1:0] instr_word;
  logic [DATA_W-1:0] instr_imm;
  logic              instr_has_imm;
  logic [ADDR_W-1:0] instr_pc;
  logic              fetch_err;

  logic [DATA_W-1:0] mem [0:63];
  int vectorsApplied = 0;
  int miscompares = 0;

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(6'd1)) dut (
    .clk(clk),
    .reset(reset),
    .fetch_en(fetch_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_word(instr_word),
    .instr_imm(instr_imm),
    .instr_has_imm(instr_has_imm),
    .instr_pc(instr_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Memory returns the word one cycle after sampling the address.
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorsApplied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy, input logic rv, input logic [ADDR_W-1:0] ra);
    fetch_en       = fe;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_addr  = ra;
  endtask

  task automatic checkInstr(input string tag, input logic [15:0] word, input logic [15:0] imm,
                            input logic has, input logic [5:0] pcv);
    checkOutput({tag, ".word"}, 32'(instr_word), 32'(word));
    checkOutput({tag, ".imm"}, 32'(instr_imm), 32'(imm));
    checkOutput({tag, ".has_imm"}, 32'(instr_has_imm), 32'(has));
    checkOutput({tag, ".pc"}, 32'(instr_pc), 32'(pcv));
  endtask

  // Called at a falling edge with the fetcher in S_ADDR; counts falling edges until instr_valid.
  task automatic waitForValid(input string tag, input int expLat);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (instr_valid) seen = 1'b1;
    end
    checkOutput({tag, ".latency"}, 32'(n), 32'(expLat));
  endtask

  task automatic stepNoValid(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput({tag, ".no_valid"}, 32'(instr_valid), 0);
    end
  endtask

  // Accept the instruction on display and land at the next S_ADDR.
  task automatic acceptInstr();
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0]  = 16'h0F0F;
    mem[1]  = 16'h3202;
    mem[2]  = 16'hB000;
    mem[3]  = 16'h0001;
    mem[4]  = 16'h4A55;
    mem[5]  = 16'h8ABC;
    mem[6]  = 16'hFFFF;
    mem[63] = 16'h2468;

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    checkOutput("rst.mem_addr", 32'(mem_addr), 1);
    checkOutput("rst.valid", 32'(instr_valid), 0);
    checkOutput("rst.err", 32'(fetch_err), 0);
    checkInstr("rst", 16'h0000, 16'h0000, 1'b0, 6'd0);

    reset = 1'b1;
    waitForValid("single", 2);
    checkInstr("single", 16'h3202, 16'h0000, 1'b0, 6'd1);
    checkOutput("single.mem_addr", 32'(mem_addr), 2);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall.valid", 32'(instr_valid), 1);
      checkOutput("stall.word", 32'(instr_word), 32'h3202);
      checkOutput("stall.mem_addr", 32'(mem_addr), 2);
    end

    acceptInstr();
    checkOutput("accept.valid", 32'(instr_valid), 0);
    waitForValid("double", 4);
    checkInstr("double", 16'hB000, 16'h0001, 1'b1, 6'd2);
    checkOutput("double.next_pc", 32'(mem_addr), 4);

    acceptInstr();
    waitForValid("imm_clear", 2);
    checkInstr("imm_clear", 16'h4A55, 16'h0000, 1'b0, 6'd4);

    acceptInstr();
    stepNoValid("partial", 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd5);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("redir.valid", 32'(instr_valid), 0);
    checkOutput("redir.imm_kept", 32'(instr_imm), 0);
    checkOutput("redir.mem_addr", 32'(mem_addr), 5);
    waitForValid("redir", 4);
    checkInstr("redir", 16'h8ABC, 16'hFFFF, 1'b1, 6'd5);

    applyStimulus(1'b1, 1'b1, 1'b1, 6'd63);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("hs_redir.valid", 32'(instr_valid), 0);
    checkOutput("hs_redir.mem_addr", 32'(mem_addr), 63);
`ifdef FETCH_WRAP_TRAP_EN
    stepNoValid("trap", 6);
    checkOutput("trap.err", 32'(fetch_err), 1);
    checkOutput("trap.pc", 32'(instr_pc), 63);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd2);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    stepNoValid("trap_hold", 4);
    checkOutput("trap_hold.err", 32'(fetch_err), 1);
    checkOutput("trap_hold.mem_addr", 32'(mem_addr), 2);
    @(negedge clk);
`else
    waitForValid("top", 2);
    checkInstr("top", 16'h2468, 16'h0000, 1'b0, 6'd63);
    checkOutput("wrap.mem_addr", 32'(mem_addr), 0);
    acceptInstr();
    waitForValid("wrap", 2);
    checkInstr("wrap", 16'h0F0F, 16'h0000, 1'b0, 6'd0);
    checkOutput("wrap.err", 32'(fetch_err), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd2);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    stepNoValid("pre_rst", 2);
`endif

    #2 reset = 1'b0;
    #1;
    checkOutput("async_rst.valid", 32'(instr_valid), 0);
    checkOutput("async_rst.mem_addr", 32'(mem_addr), 1);
    checkOutput("async_rst.err", 32'(fetch_err), 0);
    checkInstr("async_rst", 16'h0000, 16'h0000, 1'b0, 6'd0);
    @(negedge clk);
    reset = 1'b1;
    waitForValid("restart", 2);
    checkInstr("restart", 16'h3202, 16'h0000, 1'b0, 6'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end
endmodule
